cia_bus_arbiter: RTL and testbench
==================================

Name: cia_bus_arbiter

Overview:
- Shares one mos6526-style CIA register port between the CPU bus and a host/debug port (savestate, OSD monitor).
- The CPU always wins a phi2 slot. The host gets only slots where the CPU does not select the CIA.
- Blocks host reads of side-effecting registers unless forced, and times out starved host requests.
- Sits between the C64 bus decode and the CIA instance. Drives its cs_n/rw/rs/db_in and returns db_out to the winner.

Parameters:
- TIMEOUT, 1024: phi2 slots a host request may wait before failing with error.
- TW, 11: width of the timeout counter; TW >= clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- phi2_p  in  1  one-clk strobe, phi2 rising edge
- phi2_n  in  1  one-clk strobe, phi2 falling edge; the CIA performs its access here
- cpu_cs_n  in  1  CPU chip select, stable phi2_p..phi2_n
- cpu_rw  in  1  CPU read(1)/write(0)
- cpu_rs  in  4  CPU register select
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CIA read data to CPU
- host_req  in  1  one-clk request pulse; ignored while busy
- host_we  in  1  host write(1)/read(0), sampled with host_req
- host_rs  in  4  host register select, sampled with host_req
- host_wdata  in  8  host write data, sampled with host_req
- host_force  in  1  permit side-effect reads, sampled with host_req
- host_busy  out  1  request outstanding
- host_ack  out  1  one-clk completion pulse
- host_err  out  1  valid with host_ack: blocked or timed out
- host_rdata  out  8  read result, valid from host_ack until the next request
- cia_cs_n  out  1  to CIA cs_n
- cia_rw  out  1  to CIA rw
- cia_rs  out  4  to CIA rs
- cia_db_in  out  8  to CIA db_in
- cia_db_out  in  8  from CIA db_out

Behaviour:
- Reset values (asynchronous, res_n low): state IDLE; owner CPU; host_busy 0; host_ack 0; host_err 0; host_rdata 00; timeout counter 0; cia_cs_n 1; cia_rw 1; cia_rs 0; cia_db_in 00.
- Owner register, updated only on phi2_p:
  - If cpu_cs_n is 0, owner is CPU.
  - Else if state is PEND, owner is HOST and state becomes HOST_ACC.
  - Else owner is CPU.
- CIA-side mux is combinational from the owner register:
  - Owner CPU: cia_* = cpu_* unmodified. Zero added latency.
  - Owner HOST: cia_cs_n=0, cia_rw=~host_we, cia_rs/cia_db_in from the latched request.
  - When cpu_cs_n is high, cia_cs_n is 1 unless the host owns the slot.
- cpu_din = cia_db_out always. The CIA holds db_out, so CPU read timing is unchanged.
- States:
  - IDLE: on host_req, latch we/rs/wdata/force, set host_busy=1.
    - If the read is blocked, go to DONE with err=1.
    - Otherwise go to PEND with the timeout counter at 0.
  - PEND: counter increments on each phi2_p not granted to the host. On reaching TIMEOUT, go to DONE with err=1 and no CIA access.
  - HOST_ACC: wait for phi2_n; the CIA acts on that clk. Next clk go to CAPTURE.
  - CAPTURE: if the request is a read, host_rdata <= cia_db_out. Go to DONE.
  - DONE: host_ack=1 for one clk, host_err as set, host_busy=0. Go to IDLE.
- Blocked read: host_we=0, host_force=0 and rs in {8, B, C, D}. These registers have side effects (TOD latch release/latch, SDR, ICR clear).
  - Completes in 2 clks (IDLE -> DONE), host_rdata unchanged.
  - Host writes are never blocked.
- Collisions:
  - A CPU select appearing after the host was granted at phi2_p is not honoured in that slot. Bus decode guarantees cpu_cs_n is stable from phi2_p.
  - host_req while host_busy is 1 is ignored, with no ack.
- phi2_p and phi2_n in the same clk is illegal. Behaviour is undefined; SVA assertion.
- Reset mid-access aborts the request. No ack is produced after reset.
- Latency: minimum host write is req -> ack in ≤ 1 phi2 period + 3 clks when the CPU is idle.

Decomposition:
- Shared package cia_pkg:
  - state enum {IDLE, PEND, HOST_ACC, CAPTURE, DONE}.
  - Register-select constants CIA_TODT=8, CIA_TODH=B, CIA_SDR=C, CIA_ICR=D.
  - Function is_side_effect_rd(rs).
- No sub-module is needed; the timeout counter stays inline. The mux and FSM form a single module.

Test Plan:
- CPU idle, host write rs=4 data=5A: cia_cs_n=0, cia_rw=0, cia_rs=4, cia_db_in=5A at the next phi2_n; host_ack with err=0; ta_lo=5A.
- CPU reads rs=0 every slot while the host read of rs=2 is pending: host is never granted and cpu_din follows the CIA.
  - Release the CPU after 5 slots: host granted on the next phi2_p; host_rdata = ddra value.
- Host read rs=D, force=0: ack after 2 clks, err=1, no cia_cs_n low.
  - Same with force=1: ICR value returned; a subsequent CPU ICR read shows the flags cleared.
- TIMEOUT=4, CPU selects the CIA continuously: ack with err=1 exactly at the 4th denied phi2_p.
- Assert res_n during HOST_ACC: all outputs return to reset values immediately; no host_ack is issued.
- host_req pulse while busy: ignored; exactly one ack is produced, for the first request.

Source files
------------

// File: rtl/cia_pkg.sv
// Shared types and register-select constants for the CIA bus arbiter.
// Used by the arbiter RTL and by anything that decodes CIA register selects.
package cia_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        HOST_ACC,
        CAPTURE,
        DONE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

    localparam logic [3:0] CIA_TODT = 4'h8;
    localparam logic [3:0] CIA_TODH = 4'hB;
    localparam logic [3:0] CIA_SDR  = 4'hC;
    localparam logic [3:0] CIA_ICR  = 4'hD;

    // Host command captured when a request is accepted.
    typedef struct packed {
        logic       we;
        logic [3:0] rs;
        logic [7:0] wdata;
    } host_cmd_t;

    // Reading these releases/latches TOD, consumes SDR or clears ICR flags.
    function automatic logic is_side_effect_rd(input logic [3:0] rs);
        return (rs == CIA_TODT) || (rs == CIA_TODH) || (rs == CIA_SDR) || (rs == CIA_ICR);
    endfunction

endpackage

// File: rtl/cia_bus_arbiter_if.sv
// Host/debug request port of the CIA bus arbiter (savestate engine, OSD monitor).
// The host drives the request side through master; the arbiter answers through slave.
interface cia_bus_arbiter_if;

    logic       host_req;
    logic       host_we;
    logic [3:0] host_rs;
    logic [7:0] host_wdata;
    logic       host_force;
    logic       host_busy;
    logic       host_ack;
    logic       host_err;
    logic [7:0] host_rdata;

    modport master (
        output host_req, host_we, host_rs, host_wdata, host_force,
        input  host_busy, host_ack, host_err, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_rs, host_wdata, host_force,
        output host_busy, host_ack, host_err, host_rdata
    );

endinterface

// File: rtl/cia_bus_arbiter.sv
// Shares one 6526 CIA register port between the CPU and a host port. The CPU always
// wins a phi2 slot; the host borrows slots where the CPU does not select the CIA.
module cia_bus_arbiter
    import cia_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     phi2_p,
    input  logic                     phi2_n,
    input  logic                     cpu_cs_n,
    input  logic                     cpu_rw,
    input  logic [3:0]               cpu_rs,
    input  logic [7:0]               cpu_dout,
    output logic [7:0]               cpu_din,
    cia_bus_arbiter_if.slave         host,
    output logic                     cia_cs_n,
    output logic                     cia_rw,
    output logic [3:0]               cia_rs,
    output logic [7:0]               cia_db_in,
    input  logic [7:0]               cia_db_out
);

    state_t    state_q, state_d;
    owner_t    owner_q, owner_d;
    host_cmd_t cmd_q,   cmd_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic      err_q,   err_d;
    logic [7:0] rdata_q, rdata_d;
    logic      blocked;

    assign blocked = !host.host_we && !host.host_force && is_side_effect_rd(host.host_rs);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            cmd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path through this block infers a latch.
        state_d = state_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        // Ownership is re-decided at every phi2 rising edge; the CPU is the default.
        if (phi2_p) owner_d = OWN_CPU;

        unique case (state_q)
            IDLE: begin
                if (host.host_req) begin
                    cmd_d = '{we: host.host_we, rs: host.host_rs, wdata: host.host_wdata};
                    if (blocked) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (phi2_p) begin
                    if (cpu_cs_n) begin
                        owner_d = OWN_HOST;
                        state_d = HOST_ACC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == TW'(TIMEOUT)) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            HOST_ACC: begin
                if (phi2_n) state_d = CAPTURE;
            end
            CAPTURE: begin
                // The CIA holds db_out after its phi2_n access, so it is stable here.
                if (!cmd_q.we) rdata_d = cia_db_out;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cia_cs_n  = (owner_q == OWN_HOST) ? 1'b0         : cpu_cs_n;
    assign cia_rw    = (owner_q == OWN_HOST) ? !cmd_q.we    : cpu_rw;
    assign cia_rs    = (owner_q == OWN_HOST) ? cmd_q.rs     : cpu_rs;
    assign cia_db_in = (owner_q == OWN_HOST) ? cmd_q.wdata  : cpu_dout;
    assign cpu_din   = cia_db_out;

    assign host.host_busy  = (state_q == PEND) || (state_q == HOST_ACC) || (state_q == CAPTURE);
    assign host.host_ack   = (state_q == DONE);
    assign host.host_err   = (state_q == DONE) && err_q;
    assign host.host_rdata = rdata_q;

    a_phi2_exclusive: assert property (@(posedge clk) disable iff (!res_n) !(phi2_p && phi2_n));

endmodule

// File: tb/tb_cia_bus_arbiter.sv
// Randomized bench for cia_bus_arbiter: a behavioural CIA register stub on the bus side and a
// slot-level reference model that predicts host acks, errors, read data and CPU read data.
module tb_cia_bus_arbiter;
    import cia_pkg::*;

    localparam int TIMEOUT = 6;
    localparam int TW      = 3;
    localparam int PER     = 8;   // clks per phi2 period; phi2_p at clk 0, phi2_n at clk 4

    typedef logic [7:0] mem_t [16];
    typedef struct { bit sel; bit rd; logic [3:0] rs; logic [7:0] d; } cpu_op_t;
    typedef struct { int at; bit we; logic [3:0] rs; logic [7:0] wd; bit frc; } host_op_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < 16; i++) m[i] = 8'(i * 37 + 5);
        return m;
    endfunction

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       phi2_p = 1'b0, phi2_n = 1'b0;
    logic       cpu_cs_n = 1'b1, cpu_rw = 1'b1;
    logic [3:0] cpu_rs = '0;
    logic [7:0] cpu_dout = '0;
    logic [7:0] cpu_din;
    logic       cia_cs_n, cia_rw;
    logic [3:0] cia_rs;
    logic [7:0] cia_db_in, cia_db_out;

    cia_bus_arbiter_if hif ();

    cia_bus_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n),
        .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .host(hif),
        .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in), .cia_db_out(cia_db_out)
    );

    always #5 clk = ~clk;

    // CIA stub: acts on phi2_n, holds db_out, ICR read clears the flags.
    mem_t       cia_mem = init_mem();
    logic [7:0] db_out_r = 8'h00;
    int         cs_low_cnt = 0;
    int         n_access = 0;
    logic       last_rw = 1'b1;
    logic [3:0] last_rs = '0;
    logic [7:0] last_db = '0;
    assign cia_db_out = db_out_r;

    always @(posedge clk) begin
        if (res_n && !cia_cs_n) cs_low_cnt <= cs_low_cnt + 1;
        if (res_n && phi2_n && !cia_cs_n) begin
            n_access <= n_access + 1;
            last_rw  <= cia_rw;
            last_rs  <= cia_rs;
            last_db  <= cia_db_in;
            if (cia_rw) begin
                db_out_r <= cia_mem[cia_rs];
                if (cia_rs == CIA_ICR) cia_mem[cia_rs] <= 8'h00;
            end else begin
                cia_mem[cia_rs] <= cia_db_in;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state, one step per phi2 slot.
    mem_t       m_mem = init_mem();
    bit         m_pend = 1'b0;
    int         m_den = 0;
    host_op_t   m_op;
    logic [7:0] m_rdata = 8'h00;
    int         e_acks, e_iter;
    bit         e_err, e_cpu_rd;
    logic [7:0] e_rdata, e_cpu_val;

    task automatic model_slot(input cpu_op_t c, input host_op_t h);
        int free_at = 1;
        e_acks = 0;
        e_cpu_rd = 1'b0;
        if (m_pend) begin
            if (c.sel) begin
                m_den++;
                if (m_den == TIMEOUT) begin
                    m_pend = 1'b0;
                    e_acks++; e_iter = 0; e_err = 1'b1; e_rdata = m_rdata;
                    free_at = 2;
                end else begin
                    free_at = PER;
                end
            end else begin
                m_pend = 1'b0;
                if (m_op.we) m_mem[m_op.rs] = m_op.wd;
                else begin
                    m_rdata = m_mem[m_op.rs];
                    if (m_op.rs == 4'hD) m_mem[4'hD] = 8'h00;
                end
                e_acks++; e_iter = 5; e_err = 1'b0; e_rdata = m_rdata;
                free_at = 7;
            end
        end
        if (c.sel) begin
            if (c.rd) begin
                e_cpu_rd = 1'b1;
                e_cpu_val = m_mem[c.rs];
                if (c.rs == 4'hD) m_mem[4'hD] = 8'h00;
            end else begin
                m_mem[c.rs] = c.d;
            end
        end
        if (h.at >= free_at) begin
            if (!h.we && !h.frc && (h.rs == 4'h8 || h.rs == 4'hB || h.rs == 4'hC || h.rs == 4'hD)) begin
                e_acks++; e_iter = h.at; e_err = 1'b1; e_rdata = m_rdata;
            end else begin
                m_pend = 1'b1; m_den = 0; m_op = h;
            end
        end
    endtask

    function automatic cpu_op_t cpu_idle();
        cpu_op_t c = '{sel: 1'b0, rd: 1'b1, rs: 4'h0, d: 8'h00};
        return c;
    endfunction

    function automatic cpu_op_t cpu_op(input bit rd, input logic [3:0] rs, input logic [7:0] d);
        cpu_op_t c = '{sel: 1'b1, rd: rd, rs: rs, d: d};
        return c;
    endfunction

    function automatic host_op_t host_op(input int at, input bit we, input logic [3:0] rs,
                                         input logic [7:0] wd, input bit frc);
        host_op_t h = '{at: at, we: we, rs: rs, wd: wd, frc: frc};
        return h;
    endfunction

    function automatic host_op_t host_none();
        return host_op(-1, 1'b0, 4'h0, 8'h00, 1'b0);
    endfunction

    int         slot_no = 0, total_acks = 0, last_ack_slot = -1, last_ack_iter = -1;
    logic       last_ack_err;
    logic [7:0] last_ack_rdata, last_cpu_val;

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},  hif.host_busy,  1'b0);
        check({pfx, "_ack"},   hif.host_ack,   1'b0);
        check({pfx, "_err"},   hif.host_err,   1'b0);
        check({pfx, "_rdata"}, hif.host_rdata, 8'h00);
        check({pfx, "_cs_n"},  cia_cs_n,       1'b1);
        check({pfx, "_rw"},    cia_rw,         1'b1);
        check({pfx, "_rs"},    cia_rs,         4'h0);
        check({pfx, "_db_in"}, cia_db_in,      8'h00);
    endtask

    // One phi2 period. rst_at >= 0 pulses res_n inside the slot and bypasses the model.
    task automatic run_slot(input cpu_op_t c, input host_op_t h, input int rst_at);
        int acks = 0;
        if (rst_at < 0) model_slot(c, h);
        for (int cyc = 0; cyc < PER; cyc++) begin
            if (rst_at >= 0 && cyc == rst_at + 2) res_n = 1'b1;
            phi2_p = (cyc == 0);
            phi2_n = (cyc == 4);
            if (cyc == 0) begin
                cpu_cs_n = !c.sel;
                cpu_rw   = c.sel ? c.rd : 1'b1;
                cpu_rs   = c.sel ? c.rs : 4'h0;
                cpu_dout = (c.sel && !c.rd) ? c.d : 8'h00;
            end
            hif.host_req = (cyc == h.at);
            if (cyc == h.at) begin
                hif.host_we    = h.we;
                hif.host_rs    = h.rs;
                hif.host_wdata = h.wd;
                hif.host_force = h.frc;
            end
            @(posedge clk);
            #1;
            if (hif.host_ack) begin
                acks++;
                total_acks++;
                last_ack_slot  = slot_no;
                last_ack_iter  = cyc;
                last_ack_err   = hif.host_err;
                last_ack_rdata = hif.host_rdata;
            end
            if (cyc == PER - 1) last_cpu_val = cpu_din;
            if (cyc == rst_at) begin
                res_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
            end
        end
        hif.host_req = 1'b0;
        if (rst_at < 0) begin
            check("ack_count", acks, e_acks);
            if (e_acks > 0 && acks > 0) begin
                check("ack_iter",  last_ack_iter,  e_iter);
                check("ack_err",   last_ack_err,   e_err);
                check("ack_rdata", last_ack_rdata, e_rdata);
            end
            if (e_cpu_rd) check("cpu_din", last_cpu_val, e_cpu_val);
        end else begin
            m_pend  = 1'b0;
            m_rdata = 8'h00;
            check("rst_slot_no_ack", acks, 0);
        end
        slot_no++;
    endtask

    initial begin
        int s, cs0, acc0, a0, lat, p;
        cpu_op_t  c;
        host_op_t h;

        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_rs = '0;
        hif.host_wdata = '0; hif.host_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        res_n = 1'b1;

        // Host write with the CPU idle.
        acc0 = n_access;
        run_slot(cpu_idle(), host_op(3, 1'b1, 4'h4, 8'h5A, 1'b0), -1);
        run_slot(cpu_idle(), host_none(), -1);
        check("wr_accesses", n_access - acc0, 1);
        check("wr_cia_rw",   last_rw, 1'b0);
        check("wr_cia_rs",   last_rs, 4'h4);
        check("wr_cia_db",   last_db, 8'h5A);
        check("wr_ta_lo",    cia_mem[4], 8'h5A);
        lat = (PER - 3) + last_ack_iter;
        check("wr_latency_ok", (lat <= PER + 3), 1'b1);

        // Host read of DDRA starved by 5 CPU slots, then granted.
        s = slot_no;
        run_slot(cpu_op(1'b1, 4'h0, 8'h00), host_op(2, 1'b0, 4'h2, 8'h00, 1'b0), -1);
        for (int i = 0; i < 4; i++) begin
            run_slot(cpu_op(1'b1, 4'h0, 8'h00), host_none(), -1);
            check("starve_busy", hif.host_busy, 1'b1);
        end
        run_slot(cpu_idle(), host_none(), -1);
        check("starve_ack_slot", last_ack_slot - s, 5);
        check("starve_ddra",     last_ack_rdata, 8'h4F);

        // Blocked ICR read, then forced ICR read, then CPU sees flags cleared.
        run_slot(cpu_idle(), host_none(), -1);
        cs0 = cs_low_cnt;
        run_slot(cpu_idle(), host_op(2, 1'b0, 4'hD, 8'h00, 1'b0), -1);
        check("blk_no_cs",      cs_low_cnt - cs0, 0);
        check("blk_err",        last_ack_err, 1'b1);
        check("blk_rdata_kept", last_ack_rdata, 8'h4F);
        run_slot(cpu_idle(), host_op(1, 1'b0, 4'hD, 8'h00, 1'b1), -1);
        run_slot(cpu_idle(), host_none(), -1);
        check("frc_icr_val", last_ack_rdata, 8'hE6);
        run_slot(cpu_op(1'b1, 4'hD, 8'h00), host_none(), -1);
        check("frc_icr_cleared", last_cpu_val, 8'h00);

        // Timeout under continuous CPU selection.
        s = slot_no;
        run_slot(cpu_op(1'b1, 4'h0, 8'h00), host_op(1, 1'b1, 4'h7, 8'hC3, 1'b0), -1);
        for (int i = 0; i < TIMEOUT; i++) run_slot(cpu_op(1'b1, 4'h0, 8'h00), host_none(), -1);
        check("to_ack_slot", last_ack_slot - s, TIMEOUT);
        check("to_err",      last_ack_err, 1'b1);
        run_slot(cpu_op(1'b1, 4'h7, 8'h00), host_none(), -1);
        check("to_no_write", last_cpu_val, 8'h08);

        // Reset while the host owns the slot.
        a0 = total_acks;
        run_slot(cpu_idle(), host_op(6, 1'b1, 4'h5, 8'h99, 1'b0), -1);
        run_slot(cpu_idle(), host_none(), 2);
        run_slot(cpu_idle(), host_none(), -1);
        run_slot(cpu_op(1'b1, 4'h5, 8'h00), host_none(), -1);
        check("rst_no_ack",   total_acks - a0, 0);
        check("rst_aborted",  last_cpu_val, 8'hBE);

        // Second request while busy is dropped.
        a0 = total_acks;
        run_slot(cpu_op(1'b1, 4'h0, 8'h00), host_op(2, 1'b1, 4'h6, 8'hAA, 1'b0), -1);
        run_slot(cpu_op(1'b1, 4'h0, 8'h00), host_op(3, 1'b1, 4'h6, 8'h55, 1'b0), -1);
        run_slot(cpu_idle(), host_none(), -1);
        run_slot(cpu_idle(), host_none(), -1);
        run_slot(cpu_op(1'b1, 4'h6, 8'h00), host_none(), -1);
        check("busy_one_ack", total_acks - a0, 1);
        check("busy_first",   last_cpu_val, 8'hAA);

        // Random traffic with bursty CPU load.
        p = 0;
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 0) begin
                case ($urandom_range(2))
                    0:       p = 20;
                    1:       p = 60;
                    default: p = 100;
                endcase
            end
            c = cpu_idle();
            if ($urandom_range(99) < p)
                c = cpu_op(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
            h = host_none();
            if ($urandom_range(99) < 40)
                h = host_op($urandom_range(7, 1), 1'($urandom_range(1)), 4'($urandom_range(15)),
                            8'($urandom_range(255)), ($urandom_range(3) == 0));
            run_slot(c, h, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
